imuldiv_resp_writeback_queue: RTL
=================================

Name: imuldiv_resp_writeback_queue

Overview:
Downstream consumer of the iterative mul/div unit's 64-bit response port, feeding the pipeline's writeback stage.
- Records per-request writeback info (fn, destination register, half-select) at issue time in a tag FIFO.
- Pairs each in-order response with its tag and selects the 32-bit half.
- Presents a registered writeback message on a val/rdy port.

Parameters:
DEPTH, 2, maximum number of in-flight requests tracked (power of two, ≥1)
WADDR_W, 5, destination register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
issue_val  in  1  request being sent to mul/div unit this cycle
issue_rdy  out  1  tag FIFO can accept an entry
issue_fn  in  3  mul/div function code of the request
issue_hi  in  1  1 = write back result[63:32] (mulh/rem); 0 = result[31:0] (mul/quot)
issue_waddr  in  WADDR_W  destination register
resp_val  in  1  mul/div response valid
resp_rdy  out  1  response accepted
resp_result  in  64  {hi/rem, lo/quot} from mul/div unit
wb_val  out  1  writeback message valid
wb_rdy  in  1  writeback stage accepts
wb_data  out  32  selected result half
wb_waddr  out  WADDR_W  destination register
wb_fn  out  3  function code of the retired op
inflight  out  clog2(DEPTH+1)  tag FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge): count, read pointer and write pointer = 0; wb_val, wb_data, wb_waddr, wb_fn = 0.
- Reset gating: while reset==0, issue_rdy=0 and resp_rdy=0.
- Reset mid-operation discards all tags and any pending wb message; the mul/div unit shares this reset.
- Tag FIFO: circular buffer with DEPTH entries of {fn, hi, waddr}. Pointers wrap modulo DEPTH; count is kept separately.
- Push: issue_val && issue_rdy. issue_rdy = (count != DEPTH). No pop-to-push bypass: a full FIFO refuses an issue even when a pop occurs the same cycle.
- Pop: resp_val && resp_rdy. resp_rdy = (count != 0) && (!wb_val || wb_rdy). Uses registered count, so no push-to-pop bypass; a tag is poppable at the earliest one cycle after its push.
- Simultaneous push and pop: count unchanged; both pointers advance.
- On pop at edge N:
  - wb_data <= hi ? resp_result[63:32] : resp_result[31:0]
  - wb_waddr, wb_fn <= tag fields
  - wb_val = 1 from cycle N+1
- wb register:
  - Cleared on wb_val && wb_rdy unless reloaded the same edge.
  - Back-to-back pops give full throughput when wb_rdy stays high.
  - While wb_val && !wb_rdy, wb outputs hold stable and resp_rdy = 0.
- Response with empty FIFO: resp_rdy = 0. The response is held off, not dropped. The bench flags this as a protocol error.
- Ordering is strictly FIFO: the mul/div unit returns responses in issue order.
- Selection is purely by hi bit. fn is carried through only. The block does no arithmetic.
- inflight = count (tags pushed, not yet popped); it excludes the wb register.

Decomposition:
- Shared package:
  - fn encodings: MUL=3'd0, DIV=3'd1, DIVU=3'd4
  - tag record width (3+1+WADDR_W)
  - result half indices (LO=31:0, HI=63:32)
- One natural sub-module: imuldiv_tag_fifo, a generic circular queue with push/pop/full/empty/count, parameterised width and DEPTH. The top level adds the response pairing, half select and wb register.

Test Plan:
1. Issue fn=0 hi=0 waddr=3; resp 64'hfffffffe_00000001 two cycles later -> one cycle after resp fire: wb_val=1, wb_data=32'h00000001, wb_waddr=3, wb_fn=0.
2. Issue fn=4 hi=1 waddr=7; resp 64'h00000002_00000003 -> wb_data=32'h00000002 (remainder), wb_waddr=7. Repeat with hi=0 -> 32'h00000003.
3. DEPTH=2, three consecutive issue_val without responses -> first two accepted, inflight=2, issue_rdy=0 on the third. Resp accepted -> inflight=1, issue_rdy=1 next cycle.
4. Two issues (waddr 1 hi=0, waddr 2 hi=1); wb_rdy=0; resps 64'h40000000_00000000 then 64'h00000032_00000000:
   - first resp -> wb_data=32'h00000000, held stable; resp_rdy=0 for the second
   - wb_rdy=1 -> second wb_data=32'h00000032, waddr 2, order preserved
5. Empty FIFO, resp_val=1 with any result -> resp_rdy=0 every cycle, wb_val stays 0.
6. Two in flight plus wb_val=1, then reset=0 for one cycle -> inflight=0, wb_val=0. Next cycle issue_rdy=1 and resp_rdy=0.

Source files
------------

// File: rtl/imuldiv_resp_writeback_queue_pkg.sv
// Shared definitions for the mul/div response writeback queue.
// Function codes, tag layout and result half selection.
package imuldiv_resp_writeback_queue_pkg;

    localparam int FN_W = 3;

    localparam logic [FN_W-1:0] FN_MUL  = 3'd0;
    localparam logic [FN_W-1:0] FN_DIV  = 3'd1;
    localparam logic [FN_W-1:0] FN_DIVU = 3'd4;

    localparam int RESULT_W = 64;
    localparam int DATA_W   = 32;

    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;

    // Tag record is {fn, hi, waddr}
    function automatic int tag_width(input int waddr_w);
        return FN_W + 1 + waddr_w;
    endfunction

    function automatic logic [DATA_W-1:0] select_half(
        input logic [RESULT_W-1:0] result,
        input logic                hi
    );
        if (hi) begin
            return result[HI_MSB:HI_LSB];
        end
        return result[LO_MSB:LO_LSB];
    endfunction

endpackage

// File: rtl/imuldiv_tag_fifo.sv
// Generic circular tag queue with separate occupancy count.
// Push is refused when full and pop when empty, with no bypass.
module imuldiv_tag_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(
        input logic [PTR_W-1:0] ptr
    );
        if (ptr == LAST) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_resp_writeback_queue.sv
// Pairs in-order mul/div responses with issue-time tags and
// presents the selected 32-bit half on a registered wb port.
module imuldiv_resp_writeback_queue
    import imuldiv_resp_writeback_queue_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int WADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_val,
    output logic                       issue_rdy,
    input  logic [2:0]                 issue_fn,
    input  logic                       issue_hi,
    input  logic [WADDR_W-1:0]         issue_waddr,
    input  logic                       resp_val,
    output logic                       resp_rdy,
    input  logic [63:0]                resp_result,
    output logic                       wb_val,
    input  logic                       wb_rdy,
    output logic [31:0]                wb_data,
    output logic [WADDR_W-1:0]         wb_waddr,
    output logic [2:0]                 wb_fn,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int TAG_W = tag_width(WADDR_W);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]   push_tag;
    logic [TAG_W-1:0]   pop_tag;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [FN_W-1:0]    tag_fn;
    logic               tag_hi;
    logic [WADDR_W-1:0] tag_waddr;
    logic               wb_free;

    assign push_tag  = {issue_fn, issue_hi, issue_waddr};
    assign tag_fn    = pop_tag[TAG_W-1 -: FN_W];
    assign tag_hi    = pop_tag[WADDR_W];
    assign tag_waddr = pop_tag[WADDR_W-1:0];

    // A stalled wb register back-pressures the response port
    assign wb_free   = !wb_val || wb_rdy;
    assign issue_rdy = reset && !full;
    assign resp_rdy  = reset && !empty && wb_free;
    assign push      = issue_val && issue_rdy;
    assign pop       = resp_val && resp_rdy;

    imuldiv_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_tag),
        .pop       (pop),
        .pop_data  (pop_tag),
        .full      (full),
        .empty     (empty),
        .count     (inflight)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_val   <= 1'b0;
            wb_data  <= '0;
            wb_waddr <= '0;
            wb_fn    <= '0;
        end else if (pop) begin
            wb_val   <= 1'b1;
            wb_data  <= select_half(resp_result, tag_hi);
            wb_waddr <= tag_waddr;
            wb_fn    <= tag_fn;
        end else if (wb_val && wb_rdy) begin
            wb_val   <= 1'b0;
            wb_data  <= '0;
            wb_waddr <= '0;
            wb_fn    <= '0;
        end
    end

endmodule
